disp_frame_seq: RTL and testbench
=================================

# disp_frame_seq

Parametrised frame sequencer for the display pipeline. It runs up to `N` render stages (background, test pattern, samples, FFT and so on) one after another, each through a start/done pulse handshake. After the last stage it issues a buffer-swap request and waits for the swap to complete. A runtime stage-enable mask replaces compile-time stage selection, and per-stage watchdog timeouts with sticky error flags and a frame counter are added.

## Interface
Parameters:
- `N`, default 4: number of render stages; stage 0 runs first.
- `TIMEOUT`, default 0: maximum cycles to wait for `done[i]`. 0 disables the watchdog.
- `TW`, default 24: width of the watchdog counter. `TIMEOUT` must be less than 2^TW.
- `FW`, default 16: width of the frame counter.

Ports:
- `clkSYS` in 1: system clock.
- `n_reset` in 1: asynchronous, active-low reset.
- `run` in 1: level. While high, frames repeat back-to-back.
- `stage_en` in N: stage enable mask, latched at frame start.
- `start` out N: one-cycle start pulse per stage.
- `done` in N: one-cycle completion pulse per stage.
- `swap_start` out 1: one-cycle swap request.
- `swap_done` in 1: swap-complete pulse.
- `busy` out 1: high in any state other than Idle.
- `stage` out $clog2(N)+1: index of the active stage; value N means the Swap phase.
- `frame_cnt` out FW: number of completed frames, wraps modulo 2^FW.
- `err` out N: sticky timeout flag per stage.
- `err_clr` in 1: synchronous clear of `err`.

## Operation
- States:
  - **Idle**: no frame in progress.
  - **Run**: waiting for `done[stage]`.
  - **SwapWait**: waiting for `swap_done`.
- **Frame start** happens in Idle with `run`=1, or in SwapWait on `swap_done` with `run`=1.
  - Latch `stage_en` into `mask`.
  - j = lowest set bit of `mask`. Go to Run with `stage`=j and pulse `start[j]`.
  - If `mask`==0, go directly to SwapWait and pulse `swap_start`.
- **Run**, on `done[stage]`:
  - j = lowest set bit of `mask` above `stage`. Pulse `start[j]`, set `stage`=j.
  - If no such bit exists, set `stage`=N, pulse `swap_start`, go to SwapWait.
- `done[k]` is ignored when k≠`stage`, and ignored entirely outside Run.
- **SwapWait**, on `swap_done`:
  - `frame_cnt` +1, wrapping to 0 after 2^FW−1.
  - If `run`=1, start the next frame; otherwise go to Idle.
  - `swap_done` outside SwapWait is ignored.
- **Watchdog** (`TIMEOUT`>0):
  - The counter clears on every stage entry and increments each cycle in Run.
  - When it reaches TIMEOUT−1 with `done[stage]` low, set `err[stage]` and advance exactly as if done had arrived.
  - `done[stage]` high in that same cycle counts as a normal completion; `err` is not set.
- `err_clr`=1 clears all `err` bits. A timeout in the same cycle wins, so that bit is set.
- `run` dropping mid-frame: the current frame completes, including the swap, then the block goes to Idle.
- Changes to `stage_en` take effect at the next frame start only.

## Timing
- Reset values: state Idle; `start`=0, `swap_start`=0, `busy`=0, `stage`=0, `frame_cnt`=0, `err`=0, `mask`=0.
- All outputs are registered.
- `start[j]` and `swap_start` are high for exactly one cycle. They are asserted in the cycle after the edge that sampled the triggering event (`run`, `done`, or `swap_done`). There are no dead cycles between stages.
- Earliest accepted `done[j]` is the cycle after `start[j]` is high. A `done` coincident with its own `start` is ignored.
- `busy` rises together with the first `start` or `swap_start` pulse. It falls in the cycle after the final `swap_done` is sampled.
- `frame_cnt` updates in the cycle after `swap_done` is sampled.
- Asserting `n_reset` mid-frame returns the block to Idle immediately. Outputs take their reset values and no pending pulse is emitted.

## Test plan
- **Full frame.** N=4, `stage_en`=4'b1111, `run`=1, each `done` returned 3 cycles after its `start`. Expect `start[0..3]` pulses in order, then `swap_start`; after `swap_done`, `frame_cnt`=1 and the next `start[0]` one cycle later.
- **Sparse and empty mask.** With `stage_en`=4'b1010, expect only `start[1]` then `start[3]`, and `stage` showing 1, 3, 4. With `stage_en`=0, expect `swap_start` one cycle after `run` rises and no `start` pulses.
- **Watchdog.** TIMEOUT=8, `done[2]` withheld. Expect `err`=4'b0100 and `start[3]` about 8 cycles after `start[2]`. Then assert `err_clr` and expect `err`=0.
- **Stray and simultaneous events.** Drive `done[1]` while waiting on stage 0 and `swap_done` in Idle; both must be ignored. Drive `done` on the exact timeout cycle; expect no error.
- **Stop and wrap.** Drop `run` during stage 2: the frame finishes, `busy`=0 after `swap_done`. Run 2^FW frames with FW=4; `frame_cnt` wraps 15→0.
- **Reset mid-operation.** Assert `n_reset` while in SwapWait. Expect all outputs at reset values; a later `swap_done` has no effect.

Source files
------------

// File: rtl/disp_frame_seq.sv
// disp_frame_seq: runs up to N render stages one after another through start/done
// pulse handshakes, then issues a buffer-swap request and waits for it to finish.
// Frames repeat while run is high. Stage enable mask latched per frame; watchdog optional.
// Ports: clkSYS/n_reset clock and async active-low reset; run, stage_en frame control;
// start/done per-stage handshake; swap_start/swap_done swap handshake;
// busy, stage (N = swap phase), frame_cnt, err status; err_clr clears err.
module disp_frame_seq #(
  parameter int N       = 4,
  parameter int TIMEOUT = 0,
  parameter int TW      = 24,
  parameter int FW      = 16
) (
  input  logic               clkSYS,
  input  logic               n_reset,
  input  logic               run,
  input  logic [N-1:0]       stage_en,
  output logic [N-1:0]       start,
  input  logic [N-1:0]       done,
  output logic               swap_start,
  input  logic               swap_done,
  output logic               busy,
  output logic [$clog2(N):0] stage,
  output logic [FW-1:0]      frame_cnt,
  output logic [N-1:0]       err,
  input  logic               err_clr
);
  localparam int SW = $clog2(N) + 1;
  localparam logic [SW-1:0] SWAP_IDX = SW'(N);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_SWAP} state_t;

  state_t        state, state_nx;
  logic [N-1:0]  mask, mask_nx;
  logic [SW-1:0] stage_nx;
  logic [TW-1:0] wd, wd_nx;
  logic [N-1:0]  start_nx, err_nx;
  logic          swap_nx, busy_nx;
  logic [FW-1:0] frame_nx;
  logic          cur_done, accept, timeout, advance, launch, enter;
  logic [SW-1:0] first_idx, next_idx;

  // Lowest set bit of v at or above 'from'; SWAP_IDX when there is none.
  function automatic logic [SW-1:0] lowest_from(input logic [N-1:0] v, input int from);
    logic [SW-1:0] r;
    r = SWAP_IDX;
    for (int i = N - 1; i >= 0; i--)
      if (v[i] && i >= from) r = SW'(i);
    return r;
  endfunction

  // Next-state logic: stage progression and frame launch.
  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < N; i++)
      if (stage == SW'(i)) cur_done = done[i];
    // start is only non-zero in the entry cycle of a stage, so a done that
    // coincides with its own start pulse is ignored.
    accept    = (state == S_RUN) && cur_done && (start == '0);
    timeout   = (TIMEOUT > 0) && (state == S_RUN) && !accept &&
                (wd == TW'(TIMEOUT - 1));
    advance   = accept || timeout;
    first_idx = lowest_from(stage_en, 0);
    next_idx  = lowest_from(mask, int'(stage) + 1);
    launch    = 1'b0;
    state_nx  = state;
    mask_nx   = mask;
    stage_nx  = stage;
    case (state)
      S_IDLE: launch = run;
      S_RUN: begin
        if (advance) begin
          stage_nx = next_idx;
          if (next_idx == SWAP_IDX) state_nx = S_SWAP;
        end
      end
      S_SWAP: begin
        if (swap_done) begin
          if (run) begin
            launch = 1'b1;
          end else begin
            state_nx = S_IDLE;
            stage_nx = '0;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (launch) begin
      mask_nx  = stage_en;
      stage_nx = first_idx;
      state_nx = (first_idx == SWAP_IDX) ? S_SWAP : S_RUN;
    end
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    enter    = launch || advance;
    start_nx = '0;
    swap_nx  = 1'b0;
    if (enter) begin
      if (stage_nx == SWAP_IDX) begin
        swap_nx = 1'b1;
      end else begin
        for (int i = 0; i < N; i++)
          if (stage_nx == SW'(i)) start_nx[i] = 1'b1;
      end
    end
    wd_nx    = enter ? '0 : ((state == S_RUN) ? wd + 1'b1 : wd);
    busy_nx  = (state_nx != S_IDLE);
    frame_nx = (state == S_SWAP && swap_done) ? frame_cnt + 1'b1 : frame_cnt;
    // A timeout in the same cycle as err_clr still sets its bit.
    err_nx   = err_clr ? '0 : err;
    for (int i = 0; i < N; i++)
      if (timeout && stage == SW'(i)) err_nx[i] = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clkSYS or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      mask       <= '0;
      stage      <= '0;
      wd         <= '0;
      start      <= '0;
      swap_start <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      err        <= '0;
    end else begin
      state      <= state_nx;
      mask       <= mask_nx;
      stage      <= stage_nx;
      wd         <= wd_nx;
      start      <= start_nx;
      swap_start <= swap_nx;
      busy       <= busy_nx;
      frame_cnt  <= frame_nx;
      err        <= err_nx;
    end
  end

endmodule

// File: tb/tb_disp_frame_seq.sv
// tb_disp_frame_seq: directed scenarios followed by randomized stimulus for
// disp_frame_seq (N=4, TIMEOUT=8, FW=4). Every cycle's outputs are compared with
// a frame-level model: per-frame list of enabled stages, a position and a wait count.
`timescale 1ns/1ps
module tb_disp_frame_seq;
  localparam int N = 4, TOUT = 8, TW = 8, FW = 4;

  logic          clkSYS = 1'b0;
  logic          n_reset = 1'b0;
  logic          run = 1'b0;
  logic          swap_done = 1'b0;
  logic          err_clr = 1'b0;
  logic [N-1:0]  stage_en = '0;
  logic [N-1:0]  done = '0;
  logic [N-1:0]  start, err;
  logic          swap_start, busy;
  logic [2:0]    stage;
  logic [FW-1:0] frame_cnt;

  int vectors = 0, miscompares = 0;

  always #5 clkSYS = ~clkSYS;

  disp_frame_seq #(.N(N), .TIMEOUT(TOUT), .TW(TW), .FW(FW)) dut (
    .clkSYS(clkSYS), .n_reset(n_reset), .run(run), .stage_en(stage_en),
    .start(start), .done(done), .swap_start(swap_start), .swap_done(swap_done),
    .busy(busy), .stage(stage), .frame_cnt(frame_cnt), .err(err), .err_clr(err_clr)
  );

  // Model: ph 0 idle, 1 running stages, 2 waiting for swap.
  int          ph, pos, wt;
  int          q[$];
  logic [3:0]  e_start, e_err, e_frame;
  logic        e_sw, e_busy;
  logic [2:0]  e_stage;

  // Responder for directed tests: done[s] dly[s] cycles after start[s].
  bit          auto_resp;
  int          dly[4];
  int          cd[4];
  int          sw_dly, cd_sw;
  logic [3:0]  skip, extra;
  int          cyc;
  int          last_st[4];
  int          last_sw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = 0; pos = 0; wt = 0; q.delete();
    e_start = '0; e_err = '0; e_frame = '0; e_sw = 1'b0; e_busy = 1'b0; e_stage = '0;
    for (int s = 0; s < N; s++) cd[s] = 0;
    cd_sw = 0;
  endtask

  task automatic begin_frame(output logic [3:0] ns, output logic nsw);
    q.delete();
    for (int i = 0; i < N; i++) if (stage_en[i]) q.push_back(i);
    pos = 0; wt = 0; ns = '0; nsw = 1'b0;
    if (q.size() == 0) begin
      ph = 2; e_stage = 3'd4; nsw = 1'b1;
    end else begin
      ph = 1; e_stage = 3'(q[0]); ns[q[0]] = 1'b1;
    end
  endtask

  // Expected outputs after the coming clock edge, from the current inputs.
  task automatic model_step();
    logic [3:0] ns, nerr;
    logic       nsw;
    int         cur;
    bit         adv, to;
    ns = '0; nsw = 1'b0; adv = 0; to = 0;
    nerr = err_clr ? 4'b0 : e_err;
    if (ph == 1) begin
      cur = q[pos];
      if (done[cur] && wt > 0) adv = 1;
      else if (wt == TOUT - 1) begin adv = 1; to = 1; end
      if (to) nerr[cur] = 1'b1;
      if (adv) begin
        pos++;
        if (pos < q.size()) begin
          ns[q[pos]] = 1'b1; e_stage = 3'(q[pos]); wt = 0;
        end else begin
          ph = 2; e_stage = 3'd4; nsw = 1'b1;
        end
      end else begin
        wt++;
      end
    end else if (ph == 2 && swap_done) begin
      e_frame = e_frame + 4'd1;
      if (run) begin_frame(ns, nsw);
      else begin ph = 0; e_stage = '0; end
    end else if (ph == 0 && run) begin
      begin_frame(ns, nsw);
    end
    e_start = ns; e_sw = nsw; e_err = nerr; e_busy = (ph != 0);
  endtask

  task automatic compare_all();
    chk("start", start, e_start);
    chk("swap_start", swap_start, e_sw);
    chk("busy", busy, e_busy);
    chk("stage", stage, e_stage);
    chk("frame_cnt", frame_cnt, e_frame);
    chk("err", err, e_err);
  endtask

  task automatic clear_marks();
    for (int s = 0; s < N; s++) last_st[s] = -1;
    last_sw = -1;
  endtask

  task automatic tick();
    if (auto_resp) begin
      done = '0; swap_done = 1'b0;
      for (int s = 0; s < N; s++) begin
        if (cd[s] > 0) begin cd[s]--; if (cd[s] == 0) done[s] = 1'b1; end
        if (e_start[s] && !skip[s]) cd[s] = dly[s];
      end
      if (cd_sw > 0) begin cd_sw--; if (cd_sw == 0) swap_done = 1'b1; end
      if (e_sw) cd_sw = sw_dly;
      done = done | extra;
    end
    if (n_reset) model_step(); else model_reset();
    @(posedge clkSYS);
    @(negedge clkSYS);
    cyc++;
    compare_all();
    for (int s = 0; s < N; s++) if (start[s] === 1'b1) last_st[s] = cyc;
    if (swap_start === 1'b1) last_sw = cyc;
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy === 1'b0) begin ok = 1; break; end
    end
    chk(name, ok, 1);
  endtask

  initial begin
    bit ok, saw15;
    int seqv, prev;
    model_reset();
    auto_resp = 0; sw_dly = 2; skip = '0; extra = '0; cyc = 0;
    for (int s = 0; s < N; s++) dly[s] = 3;
    clear_marks();
    repeat (2) @(negedge clkSYS);
    chk("rst_busy", busy, 0);
    chk("rst_start", start, 0);
    chk("rst_stage", stage, 0);
    chk("rst_frame", frame_cnt, 0);
    chk("rst_err", err, 0);
    n_reset = 1'b1;
    tick();

    // Full frame, done 3 cycles after each start.
    auto_resp = 1; stage_en = 4'hF; run = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (last_sw >= 0) begin ok = 1; break; end end
    chk("ff_swap_seen", ok, 1);
    chk("ff_gap01", last_st[1] - last_st[0], 4);
    chk("ff_gap12", last_st[2] - last_st[1], 4);
    chk("ff_gap23", last_st[3] - last_st[2], 4);
    chk("ff_gap3s", last_sw - last_st[3], 4);
    ok = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (frame_cnt == 4'd1) begin ok = 1; break; end end
    chk("ff_frame1", ok, 1);
    chk("ff_restart", start, 4'b0001);

    // Sparse mask takes effect at the next frame start.
    stage_en = 4'b1010;
    ok = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (frame_cnt == 4'd2) begin ok = 1; break; end end
    chk("sp_frame2", ok, 1);
    chk("sp_start", start, 4'b0010);
    chk("sp_stage", stage, 1);
    seqv = 1; prev = 1; ok = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_cnt == 4'd3) begin ok = 1; break; end
      if (int'(stage) != prev) begin seqv = seqv * 10 + int'(stage); prev = int'(stage); end
    end
    chk("sp_frame3", ok, 1);
    chk("sp_seq", seqv, 134);

    // Empty mask: swap request one cycle after run rises.
    run = 1'b0;
    wait_idle("sp_idle");
    stage_en = 4'b0000; run = 1'b1;
    tick();
    chk("em_swap", swap_start, 1);
    chk("em_start", start, 0);
    chk("em_stage", stage, 4);
    run = 1'b0;
    wait_idle("em_idle");

    // swap_done in Idle is ignored.
    auto_resp = 0; done = '0; swap_done = 1'b1;
    tick();
    swap_done = 1'b0;
    chk("idle_swap_frame", frame_cnt, 5);
    chk("idle_swap_busy", busy, 0);

    // Watchdog on stage 2.
    auto_resp = 1; skip = 4'b0100; stage_en = 4'hF; run = 1'b1;
    clear_marks(); ok = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (last_st[3] >= 0) begin ok = 1; break; end end
    chk("wd_seen", ok, 1);
    chk("wd_gap23", last_st[3] - last_st[2], 8);
    chk("wd_err", err, 4'b0100);
    run = 1'b0;
    wait_idle("wd_idle");
    skip = '0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("wd_clr", err, 0);

    // Stray done[1] during stage 0; done[1] exactly on the timeout cycle.
    dly[0] = 5; dly[1] = 7; run = 1'b1;
    clear_marks(); ok = 0;
    for (int i = 0; i < 200; i++) begin
      extra = (last_st[0] >= 0 && last_st[1] < 0 && cyc == last_st[0] + 2) ? 4'b0010 : 4'b0000;
      tick();
      if (last_sw >= 0) begin ok = 1; break; end
    end
    extra = '0; run = 1'b0;
    chk("sim_seen", ok, 1);
    chk("sim_gap01", last_st[1] - last_st[0], 6);
    chk("sim_gap12", last_st[2] - last_st[1], 8);
    chk("sim_err", err, 0);
    wait_idle("sim_idle");
    dly[0] = 3; dly[1] = 3;

    // Drop run during stage 2: frame still completes.
    run = 1'b1; clear_marks(); ok = 0;
    for (int i = 0; i < 200; i++) begin tick(); if (last_st[2] >= 0) begin ok = 1; break; end end
    chk("stop_s2", ok, 1);
    run = 1'b0;
    wait_idle("stop_idle");
    chk("stop_swapped", last_sw > last_st[2], 1);
    chk("stop_frame", frame_cnt, 8);
    chk("stop_stage", stage, 0);

    // Reset while in SwapWait.
    stage_en = 4'b0000; sw_dly = 4; run = 1'b1;
    tick(); tick();
    chk("rs_inswap", busy, 1);
    n_reset = 1'b0;
    #1;
    chk("rs_busy", busy, 0);
    chk("rs_swap", swap_start, 0);
    chk("rs_frame", frame_cnt, 0);
    chk("rs_stage", stage, 0);
    model_reset();
    auto_resp = 0; run = 1'b0; swap_done = 1'b1;
    tick();
    n_reset = 1'b1;
    tick();
    swap_done = 1'b0;
    chk("rs_after_frame", frame_cnt, 0);
    chk("rs_after_busy", busy, 0);

    // 2^FW empty frames: frame_cnt wraps 15 -> 0.
    auto_resp = 1; sw_dly = 1; run = 1'b1; saw15 = 0; ok = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (saw15 && frame_cnt != 4'd15) begin chk("wrap_value", frame_cnt, 0); ok = 1; break; end
      if (frame_cnt == 4'd15) saw15 = 1;
    end
    chk("wrap_reach", ok, 1);
    run = 1'b0;
    wait_idle("wrap_idle");

    // Randomized stimulus, including stray pulses and occasional resets.
    auto_resp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      stage_en  = 4'($urandom);
      done      = 4'($urandom) & 4'($urandom);
      swap_done = ($urandom_range(0, 3) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      n_reset   = ($urandom_range(0, 399) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
